// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader controller.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_LO = 3'd1,
    HDR_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHK    = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_W          = 16;

  // States in which the byte stream is allowed to move.
  function automatic logic accepts_bytes(input state_e s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader/fetch/memory signal bundle; slave = controller side, master = driver side.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32,
  parameter int DEPTH         = 64
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     load_start;
  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     byte_ready;
  logic [ADDRESS_WIDTH-1:0] cpu_pc;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_we;
  logic [INSTR_WIDTH-1:0]   mem_wdata;
  logic                     cpu_rst_req;
  logic                     busy;
  logic                     load_done;
  logic                     load_err;
  logic [CNT_W-1:0]         word_count;

  modport slave (
    input  load_start, byte_valid, byte_data, cpu_pc,
    output byte_ready, mem_addr, mem_we, mem_wdata, cpu_rst_req,
           busy, load_done, load_err, word_count
  );

  modport master (
    output load_start, byte_valid, byte_data, cpu_pc,
    input  byte_ready, mem_addr, mem_we, mem_wdata, cpu_rst_req,
           busy, load_done, load_err, word_count
  );

endinterface

// File: rtl/imem_loader_ctrl_asm.sv
// Little-endian byte-to-word assembler; with IMEM_LOADER_CHECKSUM_EN it also
// keeps a running XOR of every data byte loaded.
module imem_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [1:0]  lane_i,
  input  logic [7:0]  byte_i,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [7:0]  xor_o,
`endif
  output logic [31:0] word_o
);

  logic [31:0] word_q;

  // Clearing on a new load keeps stale bytes from a previous image out of word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else if (clear_i) begin
      word_q <= '0;
    end else if (load_i) begin
      word_q[{lane_i, 3'b000} +: 8] <= byte_i;
    end
  end

  assign word_o = word_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_q <= '0;
    end else if (clear_i) begin
      xor_q <= '0;
    end else if (load_i) begin
      xor_q <= xor_q ^ byte_i;
    end
  end

  assign xor_o = xor_q;
`endif

endmodule

// File: rtl/imem_loader_ctrl.sv
// Instruction-memory port owner: CPU fetch passthrough when idle, byte-stream
// program loader otherwise. Trailing XOR check enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader_ctrl
  import imem_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32,
  parameter int DEPTH         = 64
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  state_e             state_q, state_d;
  logic [HDR_W-1:0]   n_q, n_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;
  logic               byte_ready_q, busy_q, cpu_rst_q, mem_we_q, done_q, err_q;

  logic               xfer;
  logic               last_word;
  logic [HDR_W-1:0]   hdr_n;
  logic               asm_clear;
  logic               asm_load;
  logic [31:0]        asm_word;

  assign xfer      = bus.byte_valid && byte_ready_q;
  assign last_word = (HDR_W'(word_idx_q) == (n_q - HDR_W'(1)));
  assign hdr_n     = {bus.byte_data, n_q[7:0]};
  assign asm_clear = (state_q == IDLE) && bus.load_start;
  assign asm_load  = (state_q == DATA) && xfer;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_acc;
`endif

  imem_byte_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .clear_i (asm_clear),
    .load_i  (asm_load),
    .lane_i  (byte_idx_q),
    .byte_i  (bus.byte_data),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .xor_o   (xor_acc),
`endif
    .word_o  (asm_word)
  );

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    word_count_d = word_count_q;
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d      = HDR_LO;
          word_idx_d   = '0;
          word_count_d = '0;
        end
      end
      HDR_LO: begin
        if (xfer) begin
          n_d[7:0] = bus.byte_data;
          state_d  = HDR_HI;
        end
      end
      HDR_HI: begin
        if (xfer) begin
          n_d = hdr_n;
          if ((hdr_n == '0) || (hdr_n > HDR_W'(DEPTH))) begin
            state_d = ERR;
          end else begin
            state_d    = DATA;
            byte_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) state_d = WRITE;
        end
      end
      WRITE: begin
        word_count_d = word_count_q + 1'b1;
        // The index stays on the last word so it never runs past DEPTH-1.
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          word_idx_d = word_idx_q + 1'b1;
          state_d    = DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer) state_d = (bus.byte_data == xor_acc) ? DONE : ERR;
      end
`endif
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      word_count_q <= '0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      cpu_rst_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      word_count_q <= word_count_d;
      byte_ready_q <= accepts_bytes(state_d);
      busy_q       <= (state_d != IDLE);
      cpu_rst_q    <= (state_d != IDLE);
      mem_we_q     <= (state_d == WRITE);
      done_q       <= (state_d == DONE);
      err_q        <= (state_d == ERR);
    end
  end

  assign bus.mem_addr    = (state_q == IDLE) ? bus.cpu_pc
                                             : ADDRESS_WIDTH'({word_idx_q, 2'b00});
  assign bus.byte_ready  = byte_ready_q;
  assign bus.busy        = busy_q;
  assign bus.cpu_rst_req = cpu_rst_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_wdata   = INSTR_WIDTH'(asm_word);
  assign bus.load_done   = done_q;
  assign bus.load_err    = err_q;
  assign bus.word_count  = word_count_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Directed bench for imem_loader_ctrl: vector table of loads plus reset,
// backpressure and full-depth sequences.
module tb_imem_loader_ctrl;

  typedef struct {
    logic [7:0]  hlo;
    logic [7:0]  hhi;
    int          nb;
    logic [63:0] d;
    bit          exp_done;
    int          exp_writes;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  imem_loader_if #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(64)) bus ();

  imem_loader_ctrl #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] wr_addr [256];
  logic [31:0] wr_data [256];
  int nw = 0, done_cnt = 0, err_cnt = 0, busy_cyc = 0, rdy_in_write = 0;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      if (nw < 256) begin
        wr_addr[nw] <= bus.mem_addr;
        wr_data[nw] <= bus.mem_wdata;
      end
      nw <= nw + 1;
      if (bus.byte_ready) rdy_in_write <= rdy_in_write + 1;
    end
    if (bus.load_done) done_cnt <= done_cnt + 1;
    if (bus.load_err)  err_cnt  <= err_cnt + 1;
    if (bus.busy)      busy_cyc <= busy_cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL send_byte_timeout actual=stalled required=byte_ready");
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b, input bit gap, input bit poke_start);
    if (gap) begin
      bus.byte_valid = 1'b0;
      bus.load_start = poke_start;
      @(negedge clk);
      bus.load_start = 1'b0;
    end
    send_byte(b);
  endtask

  task automatic wait_end(input string nm, input bit exp_done);
    int n = 0;
    while (!(bus.load_done || bus.load_err) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_end_seen"}, 64'(n < 40), 64'd1);
    chk({nm, "_pulse_kind"}, 64'(bus.load_done), 64'(exp_done));
    chk({nm, "_rst_held"}, 64'(bus.cpu_rst_req), 64'd1);
    @(negedge clk);
    chk({nm, "_rst_released"}, 64'(bus.cpu_rst_req), 64'd0);
    chk({nm, "_idle_passthru"}, 64'(bus.mem_addr), 64'(bus.cpu_pc));
    @(negedge clk);
  endtask

  task automatic run_load(input string nm, input vec_t v, input bit gap, input bit bad_chk);
    int b_nw, b_done, b_err, b_busy, exp_busy;
    bit exp_done;
    logic [7:0] xs;
    b_nw = nw; b_done = done_cnt; b_err = err_cnt; b_busy = busy_cyc;
    exp_done = v.exp_done;
    xs = 8'h00;
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    put_byte(v.hlo, gap, 1'b0);
    put_byte(v.hhi, gap, 1'b0);
    for (int i = 0; i < v.nb; i++) begin
      xs ^= v.d[8*i +: 8];
      put_byte(v.d[8*i +: 8], gap, i == 5);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (v.exp_done) begin
      put_byte(bad_chk ? 8'hFF : xs, gap, 1'b0);
      if (bad_chk) exp_done = 1'b0;
    end
`else
    if (bad_chk) exp_done = 1'b0;
`endif
    wait_end(nm, exp_done);
    chk({nm, "_done_pulses"}, 64'(done_cnt - b_done), 64'(exp_done));
    chk({nm, "_err_pulses"}, 64'(err_cnt - b_err), 64'(!exp_done));
    chk({nm, "_writes"}, 64'(nw - b_nw), 64'(v.exp_writes));
    chk({nm, "_word_count"}, 64'(bus.word_count), 64'(v.exp_writes));
    if (v.exp_writes >= 1) begin
      chk({nm, "_w0_addr"}, 64'(wr_addr[b_nw]), 64'h0);
      chk({nm, "_w0_data"}, 64'(wr_data[b_nw]), 64'(v.w0));
    end
    if (v.exp_writes >= 2) begin
      chk({nm, "_w1_addr"}, 64'(wr_addr[b_nw+1]), 64'h4);
      chk({nm, "_w1_data"}, 64'(wr_data[b_nw+1]), 64'(v.w1));
    end
    if (!gap) begin
      exp_busy = (v.exp_writes == 0) ? 3 : 3 + 5 * v.exp_writes + CHK_EXTRA;
      chk({nm, "_busy_cycles"}, 64'(busy_cyc - b_busy), 64'(exp_busy));
    end
  endtask

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_nw, b_done, bad;
    logic [7:0]  xs;
    logic [31:0] w;

    vecs[0] = '{8'h02, 8'h00, 8, 64'h00B0_0593_00A0_0513, 1'b1, 2, 32'h00A0_0513, 32'h00B0_0593};
    vecs[1] = '{8'h00, 8'h00, 0, 64'h0, 1'b0, 0, 32'h0, 32'h0};
    vecs[2] = '{8'h41, 8'h00, 0, 64'h0, 1'b0, 0, 32'h0, 32'h0};
    vecs[3] = '{8'h01, 8'h00, 4, 64'h0000_0000_1234_5678, 1'b1, 1, 32'h1234_5678, 32'h0};
    vecs[4] = '{8'h00, 8'h01, 0, 64'h0, 1'b0, 0, 32'h0, 32'h0};

    bus.load_start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.cpu_pc     = 32'h0000_0010;

    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_ready", 64'(bus.byte_ready), 64'd0);
    chk("reset_we", 64'(bus.mem_we), 64'd0);
    chk("reset_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("reset_count", 64'(bus.word_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    chk("idle_addr", 64'(bus.mem_addr), 64'h10);
    chk("idle_cpu_rst", 64'(bus.cpu_rst_req), 64'd0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    repeat (3) @(negedge clk);
    chk("idle_no_accept", 64'(bus.byte_ready), 64'd0);
    chk("idle_not_busy", 64'(bus.busy), 64'd0);
    bus.byte_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_load($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0);

    run_load("backpressure", vecs[0], 1'b1, 1'b0);
    chk("ready_low_in_write", 64'(rdy_in_write), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    run_load("chk_bad", vecs[0], 1'b0, 1'b1);
`endif

    // Reset after 6 data bytes: word 0 is already in memory, word 1 is lost.
    b_nw = nw;
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(vecs[0].d[8*i +: 8]);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_cpu_rst", 64'(bus.cpu_rst_req), 64'd0);
    chk("midrst_ready", 64'(bus.byte_ready), 64'd0);
    chk("midrst_addr", 64'(bus.mem_addr), 64'h10);
    chk("midrst_count", 64'(bus.word_count), 64'd0);
    chk("midrst_wdata", 64'(bus.mem_wdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_writes", 64'(nw - b_nw), 64'd1);
    chk("midrst_w0_data", 64'(wr_data[b_nw]), 64'h00A0_0513);
    run_load("after_rst", vecs[0], 1'b0, 1'b0);

    // Full-depth load: 64 words, last one at byte address 0xFC.
    b_nw = nw; b_done = done_cnt; xs = 8'h00;
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    send_byte(8'h40);
    send_byte(8'h00);
    for (int i = 0; i < 64; i++) begin
      w = {8'hA5, 8'(i), 8'h3C, 8'(~i)};
      for (int k = 0; k < 4; k++) begin
        xs ^= w[8*k +: 8];
        send_byte(w[8*k +: 8]);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xs);
`endif
    wait_end("depth64", 1'b1);
    chk("depth64_done", 64'(done_cnt - b_done), 64'd1);
    chk("depth64_writes", 64'(nw - b_nw), 64'd64);
    chk("depth64_count", 64'(bus.word_count), 64'd64);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      w = {8'hA5, 8'(i), 8'h3C, 8'(~i)};
      if (wr_addr[b_nw+i] !== 32'(4 * i) || wr_data[b_nw+i] !== w) bad++;
    end
    chk("depth64_contents", 64'(bad), 64'd0);
    chk("depth64_last_addr", 64'(wr_addr[b_nw+63]), 64'hFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
